// File: rtl/cache_maint_seq_pkg.sv
// Shared definitions for the cache maintenance sequencer: FSM state
// encoding, the whole-cache address marker and tag-entry field layout.
package cache_maint_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CHK  = 3'd2,
    ST_WB   = 3'd3,
    ST_WR   = 3'd4,
    ST_NEXT = 3'd5,
    ST_ACK  = 3'd6
  } state_t;

  // Request address that selects every line instead of a single one.
  localparam logic [31:0] WHOLE_CACHE_ADDR = 32'hFFFF_FFFF;

  // Tag entry is {valid, dirty, tag}. The tag occupies [TAG_W-1:0]; the
  // flag bits sit above it at TAG_W + offset.
  localparam int ENT_VALID_OFS = 1;
  localparam int ENT_DIRTY_OFS = 0;

endpackage

// File: rtl/cache_maint_seq.sv
// Cache maintenance sequencer: walks one line (or every line) of a
// direct-mapped tag RAM, writing back dirty lines on flush and clearing
// valid/dirty on invalidate.
//
// Handshakes: req_flush/req_inval are levels held by the requester until
// the one-cycle req_ack pulse; they are only sampled in IDLE. wb_req is
// raised with a fixed wb_addr and held until wb_ack is seen high at a
// rising edge; wb_ack is ignored at any other time. tag_rd returns
// tag_rdata on the following cycle; tag_wr is a single-cycle write.
module cache_maint_seq
  import cache_maint_seq_pkg::*;
#(
  parameter int IDX_W = 7,
  parameter int OFS_W = 5,
  localparam int TAG_W = 32 - IDX_W - OFS_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        req_addr,
  input  logic               req_flush,
  input  logic               req_inval,
  output logic               req_ack,
  output logic               busy,
  output logic [IDX_W-1:0]   tag_addr,
  output logic               tag_rd,
  input  logic [TAG_W+1:0]   tag_rdata,
  output logic               tag_wr,
  output logic [TAG_W+1:0]   tag_wdata,
  output logic               wb_req,
  output logic [31:0]        wb_addr,
  input  logic               wb_ack,
  output logic [2:0]         dbg_state
);

  state_t             r_state;
  logic               r_flush;
  logic               r_inval;
  logic [31:0]        r_addr;
  logic [IDX_W-1:0]   r_index;
  logic               r_tag_update;
  logic               r_req_ack;
  logic               r_busy;
  logic               r_tag_rd;
  logic               r_tag_wr;
  logic               r_wb_req;
  logic [31:0]        r_wb_addr;
  logic [TAG_W+1:0]   r_tag_wdata;

  logic               w_whole;
  logic               w_valid;
  logic               w_dirty;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic               w_need_wb;
  logic               w_need_wr;

  // Decode of the tag entry returned in CHK against the latched request.
  always_comb begin
    w_whole   = (r_addr == WHOLE_CACHE_ADDR);
    w_valid   = tag_rdata[TAG_W + ENT_VALID_OFS];
    w_dirty   = tag_rdata[TAG_W + ENT_DIRTY_OFS];
    w_tag     = tag_rdata[TAG_W-1:0];
    w_hit     = w_valid & (w_whole | (w_tag == r_addr[31 -: TAG_W]));
    w_need_wb = w_hit & w_dirty & r_flush;
    w_need_wr = w_hit & (r_inval | (w_dirty & r_flush));
  end

  // Sequencer FSM; every output is a register set on the transition into
  // the state that owns it, so strobes line up exactly with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_flush      <= 1'b0;
      r_inval      <= 1'b0;
      r_addr       <= '0;
      r_index      <= '0;
      r_tag_update <= 1'b0;
      r_req_ack    <= 1'b0;
      r_busy       <= 1'b0;
      r_tag_rd     <= 1'b0;
      r_tag_wr     <= 1'b0;
      r_wb_req     <= 1'b0;
      r_wb_addr    <= '0;
      r_tag_wdata  <= '0;
    end else begin
      r_req_ack <= 1'b0;
      r_tag_rd  <= 1'b0;
      r_tag_wr  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_flush | req_inval) begin
            r_flush  <= req_flush;
            r_inval  <= req_inval;
            r_addr   <= req_addr;
            r_index  <= (req_addr == WHOLE_CACHE_ADDR) ? '0 : req_addr[OFS_W +: IDX_W];
            r_busy   <= 1'b1;
            r_tag_rd <= 1'b1;
            r_state  <= ST_RD;
          end
        end
        ST_RD: begin
          r_state <= ST_CHK;
        end
        ST_CHK: begin
          // Invalidate keeps the old tag bits; they are don't-care once
          // valid is cleared. Flush-only preserves the tag exactly.
          r_tag_wdata  <= {~r_inval, 1'b0, w_tag};
          r_tag_update <= w_need_wr;
          if (w_need_wb) begin
            r_wb_addr <= {w_tag, r_index, {OFS_W{1'b0}}};
            r_wb_req  <= 1'b1;
            r_state   <= ST_WB;
          end else if (w_need_wr) begin
            r_tag_wr <= 1'b1;
            r_state  <= ST_WR;
          end else begin
            r_state <= ST_NEXT;
          end
        end
        ST_WB: begin
          if (wb_ack) begin
            r_wb_req <= 1'b0;
            if (r_tag_update) begin
              r_tag_wr <= 1'b1;
              r_state  <= ST_WR;
            end else begin
              r_state <= ST_NEXT;
            end
          end
        end
        ST_WR: begin
          r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          // Whole-cache walk stops at the last index; it never wraps.
          if (w_whole && (r_index != {IDX_W{1'b1}})) begin
            r_index  <= r_index + 1'b1;
            r_tag_rd <= 1'b1;
            r_state  <= ST_RD;
          end else begin
            r_req_ack <= 1'b1;
            r_state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ack   = r_req_ack;
  assign busy      = r_busy;
  assign tag_addr  = r_index;
  assign tag_rd    = r_tag_rd;
  assign tag_wr    = r_tag_wr;
  assign tag_wdata = r_tag_wdata;
  assign wb_req    = r_wb_req;
  assign wb_addr   = r_wb_addr;
  assign dbg_state = r_state;

endmodule
